sfx_audio_arbiter: RTL and testbench
====================================

Name: sfx_audio_arbiter

Overview:
Owns the single 1-bit speaker pin. It shares the speaker between two background music generators (normal and critical-health theme) and up to four one-shot sound effects (punch, kick, hit, KO).
- Sound effects take priority over music. A higher-index effect preempts a lower one.
- Music track changes happen only on a beat boundary, so a note is never cut mid-way.
- Sits between the music generators / game FSM and the top-level speaker output.

Parameters:
NUM_SFX, 4, number of effect request lines (fixed at 4 in this revision)
SFX_DUR, 25000000, effect length in clk cycles (0.25 s at 100 MHz); must be >=1
GAP_CYCLES, 2500000, silence after each effect in clk cycles; must be >=1
CNT_W, 27, width of the duration and gap counters
SFX_HP0, 113636, half-period of effect 0 (A4)
SFX_HP1, 75843, half-period of effect 1 (E5)
SFX_HP2, 56818, half-period of effect 2 (A5)
SFX_HP3, 303379, half-period of effect 3 (E3, KO thud)

Ports:
clk  in  1  system clock, 100 MHz
reset  in  1  synchronous, active-high
music_norm  in  1  square wave from the normal theme generator
music_crit  in  1  square wave from the critical theme generator
crit_mode  in  1  requested track: 0 normal, 1 critical
beat_tick  in  1  one-cycle pulse at each quaver boundary
sfx_req  in  4  one-cycle request pulses, one bit per effect
mute  in  1  forces the speaker low; sequencing continues
speaker  out  1  registered audio output
sfx_active  out  1  high while in SFX state
active_id  out  2  id of the playing (or last played) effect
track_sel  out  1  music track currently routed to the speaker

Behaviour:
Reset (synchronous, dominates all other inputs):
- state=MUSIC; speaker=0; sfx_active=0; active_id=0; track_sel=0.
- pending=0; both counters=0; tone divider cleared.
- Applies equally mid-effect or mid-gap.

Pending requests:
- pending_next = (pending & ~grant_mask) | sfx_req.
- A request arriving on the same cycle its bit is granted stays pending, so the effect plays again.
- Winner = highest-index set bit of pending.

Track select:
- When beat_tick=1, track_sel <= crit_mode. Otherwise it holds.
- Updates in every state.

States MUSIC / SFX / GAP:
- MUSIC, when pending != 0:
  - next state SFX; active_id <= winner; winner's pending bit cleared.
  - duration counter <= SFX_DUR-1; tone divider restarted.
- SFX, when a pending bit above active_id is set (preempt):
  - active_id <= winner; counter reloaded; tone restarted; that bit cleared.
  - The preempted effect is dropped.
  - Pending bits at or below active_id wait.
- SFX, counter==0 with no preempt that cycle: next state GAP; gap counter <= GAP_CYCLES-1.
- SFX, otherwise: counter decrements.
- GAP, counter==0: SFX with the winner (grant as in MUSIC) if pending != 0, else MUSIC.
- GAP, otherwise: counter decrements.
- Preemption is evaluated before expiry on the same cycle.
- Requests arriving during GAP are latched and served at the end of the gap.

Speaker (registered, 1-cycle latency):
- MUSIC: track_sel ? music_crit : music_norm.
- SFX: tone output.
- GAP: 0.
- mute=1 forces 0 in all states.
- Speaker source switches on the clk after the state change.
- sfx_active = (state==SFX), registered with the state.

Tone:
- Restart: count=0, tone=1.
- Each cycle: if count == HP[active_id]-1, then tone toggles and count=0; else count++.

Decomposition:
- Package audio_pkg:
  - state encoding (MUSIC=0, SFX=1, GAP=2);
  - default half-period constants (A4, E5, A5, E3);
  - SFX_ID width = 2.
- Sub-module sfx_tone_div:
  - inputs clk, reset, restart, half_period[CNT_W-1:0];
  - output tone;
  - a free-running toggle counter.
- The arbiter holds the FSM, the pending vector, the priority encoder and both counters.

Test Plan:
(Bench overrides: SFX_DUR=100, GAP_CYCLES=10, SFX_HP0..3=4,5,6,7.)
1. Reset: assert reset 3 cycles mid-SFX -> next clk speaker=0, sfx_active=0, active_id=0, track_sel=0; no effect plays after release without a new request.
2. Music routing: toggle music_norm; crit_mode=1 with no beat_tick -> speaker still follows music_norm 1 cycle late. Pulse beat_tick -> track_sel=1 next clk, speaker follows music_crit.
3. Single effect: pulse sfx_req=4'b0010 in MUSIC:
   - sfx_active=1 next clk, active_id=1.
   - speaker square wave, 5 cycles high / 5 low, for 100 cycles.
   - then 10 cycles of 0, then back to music.
4. Preemption: req bit 0, then bit 3 at cycle 40 -> active_id=3 next clk; counter reloads (100 more cycles at HP 7); effect 0 never resumes.
5. Simultaneous: sfx_req=4'b0110 in MUSIC -> id 2 plays 100 cycles, 10-cycle gap, then id 1 plays 100 cycles, then MUSIC.
6. Mute and re-request: mute=1 during SFX -> speaker=0 and timing unchanged. Pulse req bit 1 on its grant cycle -> effect 1 plays twice, separated by the gap.

Source files
------------

// File: rtl/sfx_audio_arbiter_pkg.sv
// Shared types and constants for the speaker arbiter.
// State encoding, default tone half-periods and the effect priority encoder.
package audio_pkg;

   typedef enum logic [1:0] {
      ST_MUSIC = 2'd0,
      ST_SFX   = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   localparam int SFX_ID_W = 2;

   localparam int HP_A4 = 113636;
   localparam int HP_E5 = 75843;
   localparam int HP_A5 = 56818;
   localparam int HP_E3 = 303379;

   // Highest set bit wins; a zero vector maps to id 0.
   function automatic logic [SFX_ID_W-1:0] win_id(
      input logic [3:0] v
   );
      logic [SFX_ID_W-1:0] id;
      priority casez (v)
         4'b1???: id = 2'd3;
         4'b01??: id = 2'd2;
         4'b001?: id = 2'd1;
         default: id = 2'd0;
      endcase
      return id;
   endfunction

endpackage

// File: rtl/sfx_audio_arbiter_tone_div.sv
// Square-wave tone generator for sound effects.
// Restart forces the wave high and clears the toggle counter.
module sfx_tone_div #(
   parameter int CNT_W = 27
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             restart,
   input  logic [CNT_W-1:0] half_period,
   output logic             tone
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt  <= '0;
         tone <= 1'b0;
      end else if (restart) begin
         cnt  <= '0;
         tone <= 1'b1;
      end else if (cnt == half_period - CNT_W'(1)) begin
         cnt  <= '0;
         tone <= ~tone;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/sfx_audio_arbiter.sv
// Speaker owner: routes music, or a prioritised one-shot effect
// followed by a short silence, onto the single speaker pin.
module sfx_audio_arbiter
   import audio_pkg::*;
#(
   parameter int NUM_SFX    = 4,
   parameter int SFX_DUR    = 25000000,
   parameter int GAP_CYCLES = 2500000,
   parameter int CNT_W      = 27,
   parameter int SFX_HP0    = HP_A4,
   parameter int SFX_HP1    = HP_E5,
   parameter int SFX_HP2    = HP_A5,
   parameter int SFX_HP3    = HP_E3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                music_norm,
   input  logic                music_crit,
   input  logic                crit_mode,
   input  logic                beat_tick,
   input  logic [NUM_SFX-1:0]  sfx_req,
   input  logic                mute,
   output logic                speaker,
   output logic                sfx_active,
   output logic [SFX_ID_W-1:0] active_id,
   output logic                track_sel
);

   localparam logic [CNT_W-1:0] DUR_LD = CNT_W'(SFX_DUR - 1);
   localparam logic [CNT_W-1:0] GAP_LD = CNT_W'(GAP_CYCLES - 1);

   state_t              state_q, state_d;
   logic [NUM_SFX-1:0]  pending_q;
   logic [NUM_SFX-1:0]  above_mask;
   logic [NUM_SFX-1:0]  grant_mask;
   logic [CNT_W-1:0]    dur_q, gap_q;
   logic [CNT_W-1:0]    hp;
   logic [SFX_ID_W-1:0] winner;
   logic                any_pend, preempt, grant;
   logic                dur_zero, gap_zero, load_gap;
   logic                spk_d, tone;

   assign winner     = win_id(pending_q);
   assign any_pend   = |pending_q;
   assign dur_zero   = (dur_q == '0);
   assign gap_zero   = (gap_q == '0);
   // Bits strictly above the playing effect.
   assign above_mask = ~((NUM_SFX'(2) << active_id) - NUM_SFX'(1));
   assign preempt    = (state_q == ST_SFX) && |(pending_q & above_mask);

   always_comb begin
      hp = CNT_W'(SFX_HP0);
      unique case (active_id)
         2'd0: hp = CNT_W'(SFX_HP0);
         2'd1: hp = CNT_W'(SFX_HP1);
         2'd2: hp = CNT_W'(SFX_HP2);
         2'd3: hp = CNT_W'(SFX_HP3);
      endcase
   end

   sfx_tone_div #(
      .CNT_W(CNT_W)
   ) u_tone (
      .clk        (clk),
      .reset      (reset),
      .restart    (grant),
      .half_period(hp),
      .tone       (tone)
   );

   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_MUSIC;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_MUSIC: if (any_pend) state_d = ST_SFX;
         ST_SFX:   if (!preempt && dur_zero) state_d = ST_GAP;
         ST_GAP:   if (gap_zero) state_d = any_pend ? ST_SFX : ST_MUSIC;
         default:  state_d = ST_MUSIC;
      endcase
   end

   always_comb begin
      grant    = 1'b0;
      load_gap = 1'b0;
      spk_d    = 1'b0;
      unique case (state_q)
         ST_MUSIC: begin
            grant = any_pend;
            spk_d = track_sel ? music_crit : music_norm;
         end
         ST_SFX: begin
            grant    = preempt;
            load_gap = !preempt && dur_zero;
            spk_d    = tone;
         end
         ST_GAP: grant = gap_zero && any_pend;
         default: ;
      endcase
      if (mute) spk_d = 1'b0;
      grant_mask = grant ? (NUM_SFX'(1) << winner) : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pending_q  <= '0;
         dur_q      <= '0;
         gap_q      <= '0;
         active_id  <= '0;
         track_sel  <= 1'b0;
         speaker    <= 1'b0;
         sfx_active <= 1'b0;
      end else begin
         // A same-cycle request re-arms its own grant.
         pending_q  <= (pending_q & ~grant_mask) | sfx_req;
         speaker    <= spk_d;
         sfx_active <= (state_d == ST_SFX);
         if (beat_tick) track_sel <= crit_mode;
         if (grant) begin
            active_id <= winner;
            dur_q     <= DUR_LD;
         end else if (state_q == ST_SFX && !dur_zero) begin
            dur_q <= dur_q - CNT_W'(1);
         end
         if (load_gap) gap_q <= GAP_LD;
         else if (state_q == ST_GAP && !gap_zero)
            gap_q <= gap_q - CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_sfx_audio_arbiter.sv
// Directed bench for sfx_audio_arbiter with a queued scoreboard.
// Stimulus pushes per-cycle expectations; a negedge monitor pops and checks.
module tb_sfx_audio_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic       music_norm, music_crit, crit_mode, beat_tick, mute;
   logic [3:0] sfx_req;
   logic       speaker, sfx_active, track_sel;
   logic [1:0] active_id;

   typedef struct packed {
      logic       spk;
      logic       act;
      logic [1:0] id;
      logic       trk;
   } exp_t;

   exp_t       sb[$];
   int         total = 0;
   int         bad = 0;
   int         cyc = 0;
   logic [1:0] cur_id = 2'd0;
   logic       exp_trk = 1'b0;

   always #5 clk = ~clk;

   sfx_audio_arbiter #(
      .NUM_SFX   (4),
      .SFX_DUR   (100),
      .GAP_CYCLES(10),
      .CNT_W     (27),
      .SFX_HP0   (4),
      .SFX_HP1   (5),
      .SFX_HP2   (6),
      .SFX_HP3   (7)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .music_norm(music_norm),
      .music_crit(music_crit),
      .crit_mode (crit_mode),
      .beat_tick (beat_tick),
      .sfx_req   (sfx_req),
      .mute      (mute),
      .speaker   (speaker),
      .sfx_active(sfx_active),
      .active_id (active_id),
      .track_sel (track_sel)
   );

   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         total++;
         if ({speaker, sfx_active, active_id, track_sel} !== e) begin
            bad++;
            $display("FAIL cyc=%0d got spk=%b act=%b id=%0d trk=%b want spk=%b act=%b id=%0d trk=%b",
                     cyc, speaker, sfx_active, active_id, track_sel,
                     e.spk, e.act, e.id, e.trk);
         end
      end
   end

   function automatic int tn(input int hp, input int j);
      return ((j / hp) % 2 == 0) ? 1 : 0;
   endfunction

   // sk: 0/1 fixed speaker level, 2 = routed music
   task automatic tick(input int sk, input logic act);
      logic rp, mp, mv, sp;
      exp_t e;
      rp = reset;
      mp = mute;
      mv = exp_trk ? music_crit : music_norm;
      sp = (sk == 2) ? mv : (sk != 0);
      if (mp) sp = 1'b0;
      if (rp) begin
         exp_trk = 1'b0;
         cur_id  = 2'd0;
      end else if (beat_tick) begin
         exp_trk = crit_mode;
      end
      @(posedge clk);
      #1;
      if (rp) e = '0;
      else    e = '{spk: sp, act: act, id: cur_id, trk: exp_trk};
      sb.push_back(e);
   endtask

   task automatic tone_run(input int hp, input int n, input int j0);
      for (int j = j0; j < j0 + n; j++) tick(tn(hp, j), 1'b1);
   endtask

   // Grant cycle, 100 cycles of tone, expiry into the gap
   task automatic effect(input logic [1:0] id, input int hp, input int first_sk);
      cur_id = id;
      tick(first_sk, 1'b1);
      tone_run(hp, 99, 0);
      tick(tn(hp, 99), 1'b0);
   endtask

   task automatic gap();
      repeat (9) tick(0, 1'b0);
   endtask

   task automatic music(input int n);
      repeat (n) tick(2, 1'b0);
   endtask

   task automatic pulse(input logic [3:0] r);
      sfx_req = r;
      tick(2, 1'b0);
      sfx_req = 4'b0;
   endtask

   initial begin
      reset      = 1'b1;
      music_norm = 1'b0;
      music_crit = 1'b0;
      crit_mode  = 1'b0;
      beat_tick  = 1'b0;
      mute       = 1'b0;
      sfx_req    = 4'b0;
      repeat (3) tick(0, 1'b0);
      reset = 1'b0;
      music(3);

      // Music routing and beat-aligned track change
      crit_mode  = 1'b1;
      music_crit = 1'b1;
      for (int i = 0; i < 10; i++) begin
         music_norm = i[0];
         tick(2, 1'b0);
      end
      beat_tick = 1'b1;
      tick(2, 1'b0);
      beat_tick  = 1'b0;
      music_norm = 1'b1;
      for (int i = 0; i < 10; i++) begin
         music_crit = i[0];
         tick(2, 1'b0);
      end
      crit_mode = 1'b0;
      beat_tick = 1'b1;
      tick(2, 1'b0);
      beat_tick  = 1'b0;
      music_crit = 1'b0;
      music(4);

      // Single effect
      pulse(4'b0010);
      effect(2'd1, 5, 2);
      gap();
      tick(0, 1'b0);
      music(5);

      // Simultaneous requests: 2 then 1
      pulse(4'b0110);
      effect(2'd2, 6, 2);
      gap();
      effect(2'd1, 5, 0);
      gap();
      tick(0, 1'b0);
      music(5);

      // Preemption of effect 0 by effect 3
      pulse(4'b0001);
      cur_id = 2'd0;
      tick(2, 1'b1);
      tone_run(4, 38, 0);
      sfx_req = 4'b1000;
      tick(tn(4, 38), 1'b1);
      sfx_req = 4'b0;
      effect(2'd3, 7, tn(4, 39));
      gap();
      tick(0, 1'b0);
      music(5);

      // Mute mid-effect and re-request on the grant cycle
      sfx_req = 4'b0010;
      tick(2, 1'b0);
      cur_id = 2'd1;
      tick(2, 1'b1);
      sfx_req = 4'b0;
      tone_run(5, 30, 0);
      mute = 1'b1;
      tone_run(5, 40, 30);
      mute = 1'b0;
      tone_run(5, 29, 70);
      tick(tn(5, 99), 1'b0);
      gap();
      effect(2'd1, 5, 0);
      gap();
      tick(0, 1'b0);
      music(5);

      // Reset held 3 cycles mid-effect
      pulse(4'b0100);
      cur_id = 2'd2;
      tick(2, 1'b1);
      tone_run(6, 20, 0);
      reset = 1'b1;
      tick(0, 1'b0);
      tick(0, 1'b0);
      tick(0, 1'b0);
      reset = 1'b0;
      music(30);

      repeat (3) @(posedge clk);
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL drain left=%0d want=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
